// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-core warp scheduler: round-robin issue, retire, memory-wait tracking
// Optional greedy re-issue of the last warp when WARP_SCHED_GREEDY_EN is defined.
module warp_scheduler #(
  parameter int NUM_WARPS             = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_WARPS-1:0]             warp_valid,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [$clog2(NUM_WARPS)-1:0]     issue_warp,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] issue_pc,
  output logic [THREADS_PER_BLOCK-1:0]     issue_mask,
  input  logic                             retire_valid,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] retire_next_pc,
  input  logic [THREADS_PER_BLOCK-1:0]     retire_mask,
  input  logic                             retire_ret,
  input  logic                             retire_mem_wait,
  input  logic [NUM_WARPS-1:0]             mem_done,
  output logic                             done
);

  localparam int WW = $clog2(NUM_WARPS);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_EXEC, S_DONE} sched_e;
  typedef enum logic [2:0] {W_INACTIVE, W_READY, W_RUNNING, W_WAITING, W_FINISHED} wstate_e;

  sched_e                           state_q;
  wstate_e                          wstate_q [NUM_WARPS];
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q     [NUM_WARPS];
  logic [THREADS_PER_BLOCK-1:0]     mask_q   [NUM_WARPS];
  logic [WW-1:0]                    last_q;
  logic                             last_valid_q;
  logic                             issue_valid_q;
  logic [WW-1:0]                    issue_warp_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] issue_pc_q;
  logic [THREADS_PER_BLOCK-1:0]     issue_mask_q;
  logic                             done_q;

  logic          found;
  logic [WW-1:0] sel;
  logic [WW-1:0] cand;
  logic          any_waiting;

  // Search starts one past the last issued warp; i == NUM_WARPS wraps back to it.
  always_comb begin
    found       = 1'b0;
    sel         = '0;
    cand        = '0;
    any_waiting = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = last_q + WW'(i);
      if (!found && wstate_q[cand] == W_READY) begin
        found = 1'b1;
        sel   = cand;
      end
    end
`ifdef WARP_SCHED_GREEDY_EN
    if (last_valid_q && wstate_q[last_q] == W_READY) begin
      found = 1'b1;
      sel   = last_q;
    end
`endif
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (wstate_q[w] == W_WAITING) any_waiting = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      for (int w = 0; w < NUM_WARPS; w++) begin
        wstate_q[w] <= W_INACTIVE;
        pc_q[w]     <= '0;
        mask_q[w]   <= '1;
      end
      last_q        <= WW'(NUM_WARPS - 1);
      last_valid_q  <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_pc_q    <= '0;
      issue_mask_q  <= '1;
      done_q        <= 1'b0;
    end else begin
      // Memory completions only wake warps already waiting; later writes below override.
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (mem_done[w] && wstate_q[w] == W_WAITING) wstate_q[w] <= W_READY;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
              wstate_q[w] <= warp_valid[w] ? W_READY : W_INACTIVE;
              pc_q[w]     <= '0;
              mask_q[w]   <= '1;
            end
            last_q       <= WW'(NUM_WARPS - 1);
            last_valid_q <= 1'b0;
            done_q       <= 1'b0;
            state_q      <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (found) begin
            issue_warp_q  <= sel;
            issue_pc_q    <= pc_q[sel];
            issue_mask_q  <= mask_q[sel];
            issue_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end else if (!any_waiting) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            wstate_q[issue_warp_q] <= W_RUNNING;
            last_q                 <= issue_warp_q;
            last_valid_q           <= 1'b1;
            issue_valid_q          <= 1'b0;
            state_q                <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (retire_valid) begin
            pc_q[issue_warp_q]   <= retire_next_pc;
            mask_q[issue_warp_q] <= retire_mask;
            if (retire_ret || retire_mask == '0) wstate_q[issue_warp_q] <= W_FINISHED;
            else if (retire_mem_wait)            wstate_q[issue_warp_q] <= W_WAITING;
            else                                 wstate_q[issue_warp_q] <= W_READY;
            state_q <= S_SELECT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;
  assign issue_pc    = issue_pc_q;
  assign issue_mask  = issue_mask_q;
  assign done        = done_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - directed self-checking bench for warp_scheduler (default round-robin build)
module tb_warp_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] warp_valid;
  logic       issue_valid;
  logic       issue_ready;
  logic [1:0] issue_warp;
  logic [7:0] issue_pc;
  logic [3:0] issue_mask;
  logic       retire_valid;
  logic [7:0] retire_next_pc;
  logic [3:0] retire_mask;
  logic       retire_ret;
  logic       retire_mem_wait;
  logic [3:0] mem_done;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  warp_scheduler #(
    .NUM_WARPS(4), .PROGRAM_MEM_ADDR_BITS(8), .THREADS_PER_BLOCK(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .warp_valid(warp_valid),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_warp(issue_warp),
    .issue_pc(issue_pc), .issue_mask(issue_mask), .retire_valid(retire_valid),
    .retire_next_pc(retire_next_pc), .retire_mask(retire_mask), .retire_ret(retire_ret),
    .retire_mem_wait(retire_mem_wait), .mem_done(mem_done), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_issue(input string tag, input logic [1:0] w, input logic [7:0] pc,
                              input logic [3:0] m);
    chk({tag, ".valid"}, 32'(issue_valid), 32'd1);
    chk({tag, ".warp"},  32'(issue_warp),  32'(w));
    chk({tag, ".pc"},    32'(issue_pc),    32'(pc));
    chk({tag, ".mask"},  32'(issue_mask),  32'(m));
  endtask

  // Handshake the pending issue, retire in EXEC, then step through SELECT.
  task automatic handshake_retire(input string tag, input logic [7:0] npc, input logic [3:0] m,
                                  input logic ret, input logic memw, input logic [3:0] md);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk({tag, ".exec_valid"}, 32'(issue_valid), 32'd0);
    retire_valid    = 1'b1;
    retire_next_pc  = npc;
    retire_mask     = m;
    retire_ret      = ret;
    retire_mem_wait = memw;
    mem_done        = md;
    tick();
    retire_valid    = 1'b0;
    retire_ret      = 1'b0;
    retire_mem_wait = 1'b0;
    mem_done        = 4'b0000;
    tick();
  endtask

  task automatic do_start(input logic [3:0] v);
    start      = 1'b1;
    warp_valid = v;
    tick();
    start      = 1'b0;
    warp_valid = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; warp_valid = 4'b0000; issue_ready = 1'b0;
    retire_valid = 1'b0; retire_next_pc = 8'h00; retire_mask = 4'h0;
    retire_ret = 1'b0; retire_mem_wait = 1'b0; mem_done = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    chk("rst.valid", 32'(issue_valid), 32'd0);
    chk("rst.warp",  32'(issue_warp),  32'd0);
    chk("rst.pc",    32'(issue_pc),    32'd0);
    chk("rst.mask",  32'(issue_mask),  32'hf);
    chk("rst.done",  32'(done),        32'd0);
    tick();
    chk("idle.valid", 32'(issue_valid), 32'd0);

    // Round-robin over all four warps, PCs stored verbatim.
    do_start(4'b1111);
    chk("launch.select_valid", 32'(issue_valid), 32'd0);
    tick();
    expect_issue("rr0", 2'd0, 8'h00, 4'hf);
    handshake_retire("rr0", 8'h10, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("rr1", 2'd1, 8'h00, 4'hf);
    handshake_retire("rr1", 8'h21, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("rr2", 2'd2, 8'h00, 4'hf);
    handshake_retire("rr2", 8'h32, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("rr3", 2'd3, 8'h00, 4'hf);
    handshake_retire("rr3", 8'h43, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("rr4", 2'd0, 8'h10, 4'hf);
    handshake_retire("rr4", 8'h14, 4'hf, 1'b1, 1'b0, 4'b0000);

    // Backpressure with stray retire and start that must be ignored in ISSUE.
    for (int c = 0; c < 5; c++) begin
      expect_issue($sformatf("bp%0d", c), 2'd1, 8'h21, 4'hf);
      retire_valid = (c < 2); retire_ret = (c < 2); start = (c < 2);
      tick();
    end
    retire_valid = 1'b0; retire_ret = 1'b0; start = 1'b0;
    expect_issue("bp5", 2'd1, 8'h21, 4'hf);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("bp.exec_valid", 32'(issue_valid), 32'd0);
    tick();
    chk("bp.exec_hold_valid", 32'(issue_valid), 32'd0);
    chk("bp.exec_hold_done",  32'(done),        32'd0);
    retire_valid = 1'b1; retire_next_pc = 8'h25; retire_mask = 4'b0011; retire_mem_wait = 1'b1;
    tick();
    retire_valid = 1'b0; retire_mem_wait = 1'b0;
    chk("bp.select_valid", 32'(issue_valid), 32'd0);
    tick();

    // Warp 1 waits on memory and is skipped until mem_done.
    expect_issue("mw2", 2'd2, 8'h32, 4'hf);
    handshake_retire("mw2", 8'h36, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("mw3", 2'd3, 8'h43, 4'hf);
    handshake_retire("mw3", 8'h47, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("mw2b", 2'd2, 8'h36, 4'hf);
    mem_done = 4'b0010;
    tick();
    mem_done = 4'b0000;
    expect_issue("mw2b_hold", 2'd2, 8'h36, 4'hf);
    handshake_retire("mw2b", 8'h3a, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("mw3b", 2'd3, 8'h47, 4'hf);
    handshake_retire("mw3b", 8'h4b, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("mw1", 2'd1, 8'h25, 4'b0011);
    // mem_done on the same edge that enters WAITING must be ignored.
    handshake_retire("mw1", 8'h29, 4'b0011, 1'b0, 1'b1, 4'b0010);
    expect_issue("aw2", 2'd2, 8'h3a, 4'hf);
    handshake_retire("aw2", 8'h3e, 4'hf, 1'b0, 1'b1, 4'b0000);
    expect_issue("aw3", 2'd3, 8'h4b, 4'hf);
    handshake_retire("aw3", 8'h4f, 4'hf, 1'b0, 1'b1, 4'b0000);

    // All live warps waiting: scheduler parks in SELECT.
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("aw.park%0d_valid", c), 32'(issue_valid), 32'd0);
      chk($sformatf("aw.park%0d_done", c),  32'(done),        32'd0);
      tick();
    end
    mem_done = 4'b1000;
    tick();
    mem_done = 4'b0000;
    chk("aw.wake_valid", 32'(issue_valid), 32'd0);
    tick();
    expect_issue("aw.wake3", 2'd3, 8'h4f, 4'hf);
    handshake_retire("aw.wake3", 8'h50, 4'hf, 1'b1, 1'b0, 4'b0000);
    chk("aw.after3_valid", 32'(issue_valid), 32'd0);
    mem_done = 4'b0110;
    tick();
    mem_done = 4'b0000;
    tick();
    expect_issue("zm1", 2'd1, 8'h29, 4'b0011);
    handshake_retire("zm1", 8'h2c, 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_issue("zm2", 2'd2, 8'h3e, 4'hf);
    handshake_retire("zm2", 8'h40, 4'hf, 1'b1, 1'b0, 4'b0000);
    chk("fin1.done",  32'(done),        32'd1);
    chk("fin1.valid", 32'(issue_valid), 32'd0);
    tick();
    chk("fin1.done_hold", 32'(done), 32'd1);

    // Completion with warps 0 and 2, then relaunch from DONE.
    do_start(4'b0101);
    chk("cmp.start_done", 32'(done), 32'd0);
    tick();
    expect_issue("cmp0a", 2'd0, 8'h00, 4'hf);
    handshake_retire("cmp0a", 8'h08, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("cmp2a", 2'd2, 8'h00, 4'hf);
    handshake_retire("cmp2a", 8'h0c, 4'hf, 1'b0, 1'b0, 4'b0000);
    expect_issue("cmp0b", 2'd0, 8'h08, 4'hf);
    handshake_retire("cmp0b", 8'h09, 4'hf, 1'b1, 1'b0, 4'b0000);
    chk("cmp.mid_done", 32'(done), 32'd0);
    expect_issue("cmp2b", 2'd2, 8'h0c, 4'hf);
    handshake_retire("cmp2b", 8'h0d, 4'hf, 1'b1, 1'b0, 4'b0000);
    chk("cmp.done", 32'(done), 32'd1);
    do_start(4'b0101);
    chk("relaunch.done", 32'(done), 32'd0);
    tick();
    expect_issue("relaunch0", 2'd0, 8'h00, 4'hf);

    // Reset while issue is pending.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_issue.valid", 32'(issue_valid), 32'd0);
    chk("rst_issue.done",  32'(done),        32'd0);
    chk("rst_issue.mask",  32'(issue_mask),  32'hf);
    tick(); tick();
    chk("rst_issue.idle_valid", 32'(issue_valid), 32'd0);

    // Empty launch reaches DONE two cycles after start.
    do_start(4'b0000);
    chk("empty.done0", 32'(done), 32'd0);
    tick();
    chk("empty.done1",  32'(done),        32'd1);
    chk("empty.valid1", 32'(issue_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
